// File: rtl/adc_capture_pkg.sv
// ---------------------------------------------------------------------------
// adc_capture_pkg
// Shared definitions for the triggered ADC capture block.
//   cap_state_e  : capture FSM states
//   NSAMP        : samples per 128-bit input beat
//   SAMPLE_BITS  : width of one MSB-aligned sample
//   BEAT_BITS    : width of one stream beat
//   FIELD_MSB/LSB: bit range of the signed field compared against the threshold
// ---------------------------------------------------------------------------
package adc_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    READOUT
  } cap_state_e;

  localparam int NSAMP       = 8;
  localparam int SAMPLE_BITS = 16;
  localparam int BEAT_BITS   = NSAMP * SAMPLE_BITS;

  // The 12-bit converter result sits in the top of each 16-bit sample.
  localparam int FIELD_MSB = 15;
  localparam int FIELD_LSB = 4;

endpackage

// File: rtl/capture_ram.sv
// ---------------------------------------------------------------------------
// capture_ram
// Simple dual-port RAM, one write port and one registered read port, single
// clock.
//   aclk            : clock
//   wr_en/addr/data : write port
//   rd_en/addr      : read request; rd_data updates one cycle later
//   rd_data         : registered read data, held while rd_en is low
// ---------------------------------------------------------------------------
module capture_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; their contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    // Holding rd_data when rd_en is low lets this register act as a pipeline
    // stage that can stall.
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_trig_capture.sv
// ---------------------------------------------------------------------------
// adc_trig_capture
// Passive tap on an ADC stream that records a circular window of DEPTH beats
// around a threshold trigger, PRETRIG of them before the trigger beat, and
// then streams the window out in write order.
//   aclk, aresetn      : clock, asynchronous active-low reset
//   s_axis_*           : input tap (tready tied high)
//   arm_i              : one-cycle pulse, starts a capture from IDLE
//   thresh_i           : signed trigger level vs sample bits [15:4]
//   m_axis_*           : readout stream, tlast on the final beat
//   busy_o             : high outside IDLE
//   trig_o             : one-cycle pulse on the trigger beat
//   sysref_i           : only with ADC_TRIG_CAPTURE_SYSREF_TRIG_EN defined;
//                        a rising edge in ARMED also triggers
// ---------------------------------------------------------------------------
module adc_trig_capture
  import adc_capture_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int PRETRIG     = 64,
  parameter int THRESH_BITS = 12
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [BEAT_BITS-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   arm_i,
  input  logic [THRESH_BITS-1:0] thresh_i,
  output logic [BEAT_BITS-1:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
`ifdef ADC_TRIG_CAPTURE_SYSREF_TRIG_EN
  input  logic                   sysref_i,
`endif
  output logic                   busy_o,
  output logic                   trig_o
);

  localparam int AW       = $clog2(DEPTH);
  localparam int POST_LEN = DEPTH - PRETRIG - 1;
  // Compared field is MSB-aligned inside the sample.
  localparam int FIELD_BASE = FIELD_LSB + (FIELD_MSB - FIELD_LSB + 1) - THRESH_BITS;

  cap_state_e state, state_nxt;

  logic [AW-1:0]        wr_ptr, pre_cnt, post_cnt, rd_addr;
  logic [AW:0]          rd_issued;
  logic                 wr_en, thresh_hit, trig_hit, trig_fire;
  logic                 rd_en, ld_out, s1_valid, s1_last;
  logic [BEAT_BITS-1:0] ram_q;

  assign s_axis_tready = 1'b1;
  assign busy_o        = (state != IDLE);

  // Any of the eight samples strictly above the level.
  always_comb begin
    thresh_hit = 1'b0;
    for (int k = 0; k < NSAMP; k++) begin
      if ($signed(s_axis_tdata[k*SAMPLE_BITS + FIELD_BASE +: THRESH_BITS]) > $signed(thresh_i))
        thresh_hit = 1'b1;
    end
  end

`ifdef ADC_TRIG_CAPTURE_SYSREF_TRIG_EN
  logic sysref_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sysref_q <= 1'b0;
    else          sysref_q <= sysref_i;
  end

  assign trig_hit = thresh_hit | (sysref_i & ~sysref_q);
`else
  assign trig_hit = thresh_hit;
`endif

  assign trig_fire = (state == ARMED) && s_axis_tvalid && trig_hit;
  assign trig_o    = trig_fire;
  assign wr_en     = s_axis_tvalid && (state == PRE || state == ARMED || state == POST);

  // NOTE: state register and counters use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm_i) state_nxt = (PRETRIG == 0) ? ARMED : PRE;
      PRE:     if (s_axis_tvalid && pre_cnt == AW'(PRETRIG - 1)) state_nxt = ARMED;
      ARMED:   if (trig_fire) state_nxt = (POST_LEN == 0) ? READOUT : POST;
      POST:    if (s_axis_tvalid && post_cnt == AW'(POST_LEN - 1)) state_nxt = READOUT;
      READOUT: if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Readout pipeline: RAM read register (s1) feeding the output register.
  // A stalled output register holds its beat, and s1 holds the next one by
  // withholding rd_en, so nothing is lost or repeated under backpressure.
  assign ld_out = s1_valid && (!m_axis_tvalid || m_axis_tready);
  assign rd_en  = (state == READOUT) && (rd_issued != (AW+1)'(DEPTH)) &&
                  (!s1_valid || ld_out);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_addr   <= '0;
      rd_issued <= '0;
    end else if (state == IDLE && arm_i) begin
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_issued <= '0;
    end else begin
      if (wr_en)                         wr_ptr   <= wr_ptr + 1'b1;
      if (state == PRE && s_axis_tvalid)  pre_cnt  <= pre_cnt + 1'b1;
      if (state == POST && s_axis_tvalid) post_cnt <= post_cnt + 1'b1;
      // Window start (T - PRETRIG) wraps naturally in AW bits.
      if (trig_fire) rd_addr <= wr_ptr - AW'(PRETRIG);
      if (rd_en) begin
        rd_addr   <= rd_addr + 1'b1;
        rd_issued <= rd_issued + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (rd_en) begin
        s1_valid <= 1'b1;
        s1_last  <= (rd_issued == (AW+1)'(DEPTH - 1));
      end else if (ld_out) begin
        s1_valid <= 1'b0;
      end

      if (ld_out) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ram_q;
        m_axis_tlast  <= s1_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

  capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_BITS),
    .AW    (AW)
  ) u_ram (
    .aclk    (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule

// File: doc/adc_trig_capture.md
ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

Interface
REQ-001 Parameter DEPTH, default 512: capture length in 128-bit beats; power of two, 64..4096.
REQ-002 Parameter PRETRIG, default 64: beats retained before the trigger beat; must be less than DEPTH.
REQ-003 Parameter THRESH_BITS, default 12: width of the threshold and of the compared sample field.
REQ-004 aclk  in  1  single clock; all logic is rising-edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 s_axis_tdata  in  128  eight 16-bit MSB-aligned samples; sample 0 is in bits [15:0].
REQ-007 s_axis_tvalid  in  1  input beat valid.
REQ-008 s_axis_tready  out  1  always 1 out of reset; the block is a passive tap.
REQ-009 arm_i  in  1  single-cycle pulse that starts a capture.
REQ-010 thresh_i  in  THRESH_BITS  signed trigger level, compared against sample bits [15:4].
REQ-011 m_axis_tdata  out  128  readout data.
REQ-012 m_axis_tvalid  out  1  readout beat valid.
REQ-013 m_axis_tready  in  1  readout backpressure.
REQ-014 m_axis_tlast  out  1  asserted on the final readout beat.
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 trig_o  out  1  one-cycle pulse on the trigger beat.

Function
REQ-017 The block has five states: IDLE, PRE, ARMED, POST and READOUT.
REQ-018 IDLE -> PRE when arm_i=1; the write pointer and pretrigger counter clear in the same cycle.
REQ-019 Beats are written to circular RAM only when s_axis_tvalid=1; the write address wraps modulo DEPTH.
REQ-020 PRE -> ARMED after PRETRIG valid beats have been written; a trigger during PRE is ignored.
REQ-021 In ARMED, a valid beat triggers when any of its 8 samples, signed [15:4], is strictly greater than thresh_i.
REQ-022 On trigger: the trigger beat is written, its address is latched as T, trig_o pulses, and the state moves to POST.
REQ-023 POST writes DEPTH-PRETRIG-1 further valid beats, then moves to READOUT.
REQ-024 READOUT emits DEPTH beats starting at address (T-PRETRIG) mod DEPTH, in write order.
REQ-025 The readout path has one-cycle RAM latency behind a skid register; tdata and tlast are held stable while tvalid=1 and tready=0.
REQ-026 m_axis_tlast=1 only on beat DEPTH-1; after that handshake the state returns to IDLE.
REQ-027 arm_i is ignored in every state other than IDLE.
REQ-028 Input writes continue to be accepted and discarded during READOUT and IDLE; s_axis_tready never deasserts.
REQ-029 If a trigger and arm_i occur in the same cycle in IDLE, the block takes only the arm and the trigger is ignored.

Reset
REQ-030 While aresetn=0: state=IDLE; m_axis_tvalid, m_axis_tlast, busy_o and trig_o=0; s_axis_tready=1; pointers and counters=0.
REQ-031 Reset mid-capture or mid-readout abandons the capture; RAM contents are not cleared and are don't-care.

Configuration
REQ-032 Macro ADC_TRIG_CAPTURE_SYSREF_TRIG_EN, when defined, adds port sysref_i (in, 1); a rising edge of sysref_i seen in ARMED also triggers, ORed with the threshold trigger.
REQ-033 Without ADC_TRIG_CAPTURE_SYSREF_TRIG_EN the port is absent and only the threshold trigger exists.

Structure
REQ-034 Shared package adc_capture_pkg holds the state enum, NSAMP=8, SAMPLE_BITS=16 and the sample-field slice constants.
REQ-035 One sub-module, capture_ram: simple dual-port RAM, DEPTH x 128, registered read, single clock.

Verification
REQ-036 Arm; ramp input; thresh=100; first sample of 101 at beat 300 -> trig_o at beat 300; readout beats 236..747 in order; tlast on the 512th beat.
REQ-037 Trigger-level sample arrives during PRE at beat 10 -> no trigger; a later crossing at beat 90 triggers.
REQ-038 m_axis_tready toggled 1/0 randomly -> no lost or duplicated beats; data stable while stalled.
REQ-039 s_axis_tvalid at a 50% duty cycle -> only valid beats are stored; readout is contiguous in valid-beat order.
REQ-040 aresetn pulsed low in POST -> all outputs at reset values next cycle; a fresh arm captures correctly.
REQ-041 With ADC_TRIG_CAPTURE_SYSREF_TRIG_EN and thresh=2047, a sysref_i rising edge in ARMED -> trigger on that beat.
